// File: rtl/gsim_pkg.sv
`default_nettype none
// ============================================================================
// gsim_pkg : shared sizes, Q-format widths and FSM state type. Rev 1.0
// ============================================================================
package gsim_pkg;

   localparam int GSIM_N_ELEM   = 16;
   localparam int GSIM_W_X      = 32;
   localparam int GSIM_FRAC_IN  = 16;
   localparam int GSIM_FRAC_OUT = 8;
   localparam int GSIM_W_Q      = 16;

   typedef enum logic [0:0] {
      ST_COLLECT = 1'b0,
      ST_DRAIN   = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/gsim_q_sat.sv
`default_nettype none
// ============================================================================
// gsim_q_sat : Q16.16 -> Q8.8 conversion, round-half-up then saturate. Rev 1.0
// ============================================================================
module gsim_q_sat
   import gsim_pkg::*;
#(
   parameter int W_IN     = GSIM_W_X,
   parameter int FRAC_IN  = GSIM_FRAC_IN,
   parameter int FRAC_OUT = GSIM_FRAC_OUT,
   parameter int W_OUT    = GSIM_W_Q
) (
   input  logic [W_IN-1:0]  in_x,
   output logic [W_OUT-1:0] out_q
);

   localparam int SHIFT = FRAC_IN - FRAC_OUT;
   localparam int W_SHR = W_IN + 1 - SHIFT;
   localparam logic signed [W_IN:0]    RND   = (W_IN+1)'(1 << (SHIFT - 1));
   localparam logic signed [W_SHR-1:0] Q_MAX = W_SHR'((1 << (W_OUT - 1)) - 1);
   localparam logic signed [W_SHR-1:0] Q_MIN = W_SHR'(-(1 << (W_OUT - 1)));

   // One guard bit keeps the rounding add from wrapping near full scale.
   logic signed [W_IN:0]    sum_w;
   logic signed [W_SHR-1:0] shr_w;

   assign sum_w = $signed({in_x[W_IN-1], in_x}) + RND;
   assign shr_w = $signed(sum_w[W_IN:SHIFT]);

   always_comb begin
      out_q = shr_w[W_OUT-1:0];
      if (shr_w > Q_MAX) begin
         out_q = Q_MAX[W_OUT-1:0];
      end else if (shr_w < Q_MIN) begin
         out_q = Q_MIN[W_OUT-1:0];
      end
   end

endmodule
`default_nettype wire

// File: rtl/gsim_result_collector.sv
`default_nettype none
// ============================================================================
// gsim_result_collector : buffers one solver frame, then drains it with
// ready/valid handshaking and a Q8.8 view of each word. Rev 1.0
// ============================================================================
module gsim_result_collector
   import gsim_pkg::*;
#(
   parameter int N_ELEM = GSIM_N_ELEM,
   parameter int W_X    = GSIM_W_X
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   input  logic [W_X-1:0]      in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [W_X-1:0]      out_data,
   output logic [GSIM_W_Q-1:0] out_q,
   output logic [3:0]          out_idx,
   output logic                out_last,
   output logic                done,
   output logic                ovf_err
);

   localparam int CW = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(N_ELEM - 1);

   state_t         state_q, state_d;
   logic [CW-1:0]  wr_cnt_q, wr_cnt_d;
   logic [CW-1:0]  rd_ptr_q, rd_ptr_d;
   logic           done_q, done_d;
   logic           ovf_err_q, ovf_err_d;
   logic [W_X-1:0] buf_q [N_ELEM];
   logic [W_X-1:0] buf_d [N_ELEM];
   logic           wr_en;

   always_comb begin
      state_d   = state_q;
      wr_cnt_d  = wr_cnt_q;
      rd_ptr_d  = rd_ptr_q;
      done_d    = 1'b0;
      ovf_err_d = ovf_err_q;
      wr_en     = 1'b0;
      case (state_q)
         ST_COLLECT: begin
            if (in_valid) begin
               wr_en = 1'b1;
               if (wr_cnt_q == LAST_IDX) begin
                  wr_cnt_d = '0;
                  state_d  = ST_DRAIN;
               end else begin
                  wr_cnt_d = wr_cnt_q + 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            // Words arriving while draining are dropped, even on the final handshake.
            if (in_valid) begin
               ovf_err_d = 1'b1;
            end
            if (out_ready) begin
               if (rd_ptr_q == LAST_IDX) begin
                  rd_ptr_d = '0;
                  state_d  = ST_COLLECT;
                  done_d   = 1'b1;
               end else begin
                  rd_ptr_d = rd_ptr_q + 1'b1;
               end
            end
         end
         default: state_d = ST_COLLECT;
      endcase
   end

   always_comb begin
      buf_d = buf_q;
      if (wr_en) begin
         buf_d[wr_cnt_q] = in_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_COLLECT;
         wr_cnt_q  <= '0;
         rd_ptr_q  <= '0;
         done_q    <= 1'b0;
         ovf_err_q <= 1'b0;
         for (int i = 0; i < N_ELEM; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_ptr_q  <= rd_ptr_d;
         done_q    <= done_d;
         ovf_err_q <= ovf_err_d;
         buf_q     <= buf_d;
      end
   end

   assign out_valid = (state_q == ST_DRAIN);
   assign out_data  = buf_q[rd_ptr_q];
   assign out_idx   = 4'(rd_ptr_q);
   assign out_last  = out_valid && (rd_ptr_q == LAST_IDX);
   assign done      = done_q;
   assign ovf_err   = ovf_err_q;

   gsim_q_sat #(
      .W_IN     (W_X),
      .FRAC_IN  (GSIM_FRAC_IN),
      .FRAC_OUT (GSIM_FRAC_OUT),
      .W_OUT    (GSIM_W_Q)
   ) u_q_sat (
      .in_x  (out_data),
      .out_q (out_q)
   );

endmodule
`default_nettype wire

// File: tb/tb_gsim_result_collector.sv
`default_nettype none
// ============================================================================
// tb_gsim_result_collector : randomized self-checking bench for the collector.
// ============================================================================
module tb_gsim_result_collector;

   localparam int N = 16;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic [W-1:0]  in_data;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic [15:0]   out_q;
   logic [3:0]    out_idx;
   logic          out_last;
   logic          done;
   logic          ovf_err;

   int n_cmp  = 0;
   int n_fail = 0;

   gsim_result_collector #(.N_ELEM(N), .W_X(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_q     (out_q),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .done      (done),
      .ovf_err   (ovf_err)
   );

   always #5 clk = ~clk;

   // Reference conversion: real value, scaled to Q8.8, rounded half up, clamped.
   function automatic logic [15:0] model_q(input logic [31:0] x);
      real    r;
      longint v;
      r = $itor($signed(x)) / 65536.0;
      v = longint'($floor(r * 256.0 + 0.5));
      if (v > 32767)  v = 32767;
      if (v < -32768) v = -32768;
      return v[15:0];
   endfunction

   task automatic do_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_idle(input string name);
      n_cmp++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || done !== 1'b0 || ovf_err !== 1'b0 ||
          out_data !== '0 || out_q !== 16'h0 || out_idx !== 4'h0) begin
         n_fail++;
         $display("FAIL %s: valid=%b last=%b done=%b ovf=%b data=%h q=%h idx=%0d, expected all zero",
                  name, out_valid, out_last, done, ovf_err, out_data, out_q, out_idx);
      end
   endtask

   task automatic send_frame(input logic [31:0] w[$], input int gap);
      for (int i = 0; i < N; i++) begin
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL collect_valid[%0d]: out_valid=%b, expected 0", i, out_valid);
         end
         in_valid = 1'b1;
         in_data  = w[i];
         @(negedge clk);
         in_valid = 1'b0;
         in_data  = $urandom;
         if (i < N - 1) repeat (gap) @(negedge clk);
      end
      n_cmp++;
      if (out_valid !== 1'b1 || out_idx !== 4'h0) begin
         n_fail++;
         $display("FAIL latency: out_valid=%b idx=%0d, expected valid=1 idx=0", out_valid, out_idx);
      end
   endtask

   task automatic drain_frame(input logic [31:0] w[$], input bit rnd_ready,
                              input int inject_cyc, input bit inject_final);
      int k   = 0;
      int cyc = 0;
      bit hs;
      while (k < N && cyc < 1000) begin
         n_cmp++;
         if (out_valid !== 1'b1 || out_data !== w[k] || out_q !== model_q(w[k]) ||
             out_idx !== 4'(k) || out_last !== (k == N - 1) || done !== 1'b0) begin
            n_fail++;
            $display("FAIL drain[%0d]: valid=%b data=%h q=%h idx=%0d last=%b done=%b, expected 1 %h %h %0d %b 0",
                     k, out_valid, out_data, out_q, out_idx, out_last, done,
                     w[k], model_q(w[k]), k, (k == N - 1));
         end
         out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         in_valid  = (cyc == inject_cyc) || (inject_final && k == N - 1 && out_ready);
         in_data   = $urandom;
         hs        = out_ready;
         @(negedge clk);
         cyc++;
         if (hs) k++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      n_cmp++;
      if (k < N) begin
         n_fail++;
         $display("FAIL drain_timeout: delivered=%0d, expected %0d", k, N);
      end
      n_cmp++;
      if (done !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0) begin
         n_fail++;
         $display("FAIL done_pulse: done=%b valid=%b last=%b, expected 1 0 0", done, out_valid, out_last);
      end
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL done_width: done=%b valid=%b, expected 0 0", done, out_valid);
      end
   endtask

   task automatic check_ovf(input string name, input logic exp);
      n_cmp++;
      if (ovf_err !== exp) begin
         n_fail++;
         $display("FAIL %s: ovf_err=%b, expected %b", name, ovf_err, exp);
      end
   endtask

   task automatic ramp_frame(output logic [31:0] w[$]);
      w = {};
      for (int i = 0; i < N; i++) w.push_back(32'(i + 1) << 16);
   endtask

   task automatic rand_frame(output logic [31:0] w[$]);
      w = {};
      for (int i = 0; i < N; i++) w.push_back($urandom);
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      #1;
      check_idle("reset_async");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_idle("reset_release");
   endtask

   task automatic test_back_to_back();
      logic [31:0] w[$];
      ramp_frame(w);
      send_frame(w, 0);
      drain_frame(w, 1'b0, -1, 1'b0);
   endtask

   task automatic test_conversion();
      logic [31:0] w[$];
      w = {32'h0001_8000, 32'h7FFF_0000, 32'h8000_0000, 32'hFFFF_8080,
           32'h0000_007F, 32'h0000_0080, 32'h7FFF_FFFF, 32'hFFFF_FF80};
      while (w.size() < N) w.push_back($urandom);
      send_frame(w, 0);
      drain_frame(w, 1'b0, -1, 1'b0);
   endtask

   task automatic test_stall();
      logic [31:0] w[$];
      for (int f = 0; f < 2; f++) begin
         rand_frame(w);
         send_frame(w, f);
         drain_frame(w, 1'b1, -1, 1'b0);
      end
   endtask

   task automatic test_gaps();
      logic [31:0] w[$];
      ramp_frame(w);
      send_frame(w, 3);
      drain_frame(w, 1'b0, -1, 1'b0);
   endtask

   task automatic test_overflow();
      logic [31:0] w[$];
      check_ovf("ovf_before", 1'b0);
      rand_frame(w);
      send_frame(w, 0);
      drain_frame(w, 1'b1, 3, 1'b0);
      check_ovf("ovf_set", 1'b1);
      rand_frame(w);
      send_frame(w, 1);
      drain_frame(w, 1'b0, -1, 1'b0);
      check_ovf("ovf_sticky", 1'b1);
   endtask

   task automatic test_overflow_final();
      logic [31:0] w[$];
      do_reset();
      check_ovf("ovf_cleared", 1'b0);
      rand_frame(w);
      send_frame(w, 0);
      drain_frame(w, 1'b1, -1, 1'b1);
      check_ovf("ovf_final", 1'b1);
      rand_frame(w);
      send_frame(w, 0);
      drain_frame(w, 1'b0, -1, 1'b0);
   endtask

   task automatic test_reset_abort();
      logic [31:0] w[$];
      do_reset();
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1;
         in_data  = $urandom;
         @(negedge clk);
      end
      in_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      check_idle("abort_collect");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      rand_frame(w);
      send_frame(w, 0);
      drain_frame(w, 1'b0, -1, 1'b0);
      // Abort partway through a drain as well.
      rand_frame(w);
      send_frame(w, 0);
      out_ready = 1'b1;
      repeat (5) @(negedge clk);
      out_ready = 1'b0;
      #2 reset = 1'b1;
      #1;
      check_idle("abort_drain");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      rand_frame(w);
      send_frame(w, 2);
      drain_frame(w, 1'b1, -1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_conversion();
      test_stall();
      test_gaps();
      test_overflow();
      test_overflow_final();
      test_reset_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
